// File: rtl/controlador_carga_instrucoes_if.sv
// Loader, instruction-memory write port and CPU fetch-control bundle for the
// instruction-memory boot-loader / fetch sequencer.
interface controlador_carga_instrucoes_if #(
  parameter int ADDR_W = 3
);
  logic              carga_valido;
  logic [31:0]       carga_dado;
  logic              carga_fim;
  logic              carga_pronto;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic [31:0]       cpu_pc;
  logic              cpu_enable;
  logic              recarregar;
  logic [1:0]        estado;
  logic [ADDR_W:0]   num_carregadas;
  logic [15:0]       ciclos_exec;

  // Environment side: program source, CPU and control.
  modport master (
    output carga_valido, carga_dado, carga_fim, cpu_pc, recarregar,
    input  carga_pronto, mem_we, mem_waddr, mem_wdata, cpu_enable,
           estado, num_carregadas, ciclos_exec
  );

  // Sequencer side.
  modport slave (
    input  carga_valido, carga_dado, carga_fim, cpu_pc, recarregar,
    output carga_pronto, mem_we, mem_waddr, mem_wdata, cpu_enable,
           estado, num_carregadas, ciclos_exec
  );
endinterface

// File: rtl/controlador_carga_instrucoes.sv
// Boot-loader and fetch sequencer: streams a program into instruction memory,
// then runs the CPU until the fetch PC leaves the program or is misaligned.
module controlador_carga_instrucoes #(
  parameter int NUM_PALAVRAS = 8,
  parameter int ADDR_W       = 3
) (
  input logic i_clk,
  input logic i_reset,
  controlador_carga_instrucoes_if.slave bus
);

  typedef enum logic [1:0] {
    CARGA   = 2'b00,
    EXECUTA = 2'b01,
    PARADO  = 2'b10,
    ERRO    = 2'b11
  } estado_t;

  localparam logic [ADDR_W:0] ULTIMO = (ADDR_W+1)'(NUM_PALAVRAS - 1);

  estado_t         r_estado;
  estado_t         w_proximo;
  logic [ADDR_W:0] r_contador;
  logic [ADDR_W:0] r_num;
  logic [15:0]     r_ciclos;
  logic            w_pronto;
  logic            w_aceita;
  logic            w_enable;
  logic            w_fora;
  logic            w_desal;
  logic            w_limpa;

  // Fetch range is checked against the loaded word count, zero-extended to 30 bits.
  assign w_fora  = (bus.cpu_pc[31:2] >= {{(29-ADDR_W){1'b0}}, r_num});
  assign w_desal = (bus.cpu_pc[1:0] != 2'b00);

  // Next-state and combinational handshake/enable outputs.
  always_comb begin
    w_proximo = r_estado;
    w_pronto  = 1'b0;
    w_aceita  = 1'b0;
    w_enable  = 1'b0;
    w_limpa   = 1'b0;
    case (r_estado)
      CARGA: begin
        w_pronto = ~i_reset;
        w_aceita = bus.carga_valido & w_pronto;
        if (w_aceita && (bus.carga_fim || (r_contador == ULTIMO))) begin
          w_proximo = EXECUTA;
        end else begin
          w_proximo = CARGA;
        end
      end
      EXECUTA: begin
        w_enable = ~w_fora & ~w_desal & ~i_reset;
        if (bus.recarregar) begin
          w_proximo = CARGA;
          w_limpa   = 1'b1;
        end else if (w_desal) begin
          w_proximo = ERRO;
        end else if (w_fora) begin
          w_proximo = PARADO;
        end else begin
          w_proximo = EXECUTA;
        end
      end
      PARADO, ERRO: begin
        if (bus.recarregar) begin
          w_proximo = CARGA;
          w_limpa   = 1'b1;
        end else begin
          w_proximo = r_estado;
        end
      end
      default: begin
        w_proximo = CARGA;
      end
    endcase
  end

  // State, load counters and saturating execution-cycle counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_estado   <= CARGA;
      r_contador <= '0;
      r_num      <= '0;
      r_ciclos   <= 16'd0;
    end else begin
      r_estado <= w_proximo;
      if (w_limpa) begin
        r_contador <= '0;
        r_num      <= '0;
        r_ciclos   <= 16'd0;
      end else begin
        if (w_aceita) begin
          r_contador <= r_contador + (ADDR_W+1)'(1);
          r_num      <= r_contador + (ADDR_W+1)'(1);
        end else begin
          r_contador <= r_contador;
          r_num      <= r_num;
        end
        if (w_enable && (r_ciclos != 16'hFFFF)) begin
          r_ciclos <= r_ciclos + 16'd1;
        end else begin
          r_ciclos <= r_ciclos;
        end
      end
    end
  end

  assign bus.carga_pronto   = w_pronto;
  assign bus.mem_we         = w_aceita;
  assign bus.mem_waddr      = r_contador[ADDR_W-1:0];
  assign bus.mem_wdata      = bus.carga_dado;
  assign bus.cpu_enable     = w_enable;
  assign bus.estado         = r_estado;
  assign bus.num_carregadas = r_num;
  assign bus.ciclos_exec    = r_ciclos;

endmodule
